event_blinker: RTL

//  Output-side counterpart of the push-button input chain. The chain turns a human press

---
 rtl/event_blinker_if.sv | 35 +++
 rtl/event_blinker.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/event_blinker_if.sv
// ----------------------------------------------------------------------------
// event_blinker_if
// Purpose : bundles the event strobe and the blink status signals of
//           event_blinker into one interface.
// Signals : pulse      - 1-clk event strobe (driven by master)
//           led        - blink output
//           busy       - blink or gap in progress
//           pend_count - queued events not yet started
//           overflow   - event dropped because the queue was full
//           ovf_clr    - sticky overflow clear (only with OVERFLOW_STICKY_EN)
// Modports: master drives pulse (and ovf_clr); slave is the blinker itself.
// Macro   : OVERFLOW_STICKY_EN adds the ovf_clr signal.
// ----------------------------------------------------------------------------
interface event_blinker_if #(
  parameter int PEND_W = 3
);
  logic              pulse;
  logic              led;
  logic              busy;
  logic [PEND_W-1:0] pend_count;
  logic              overflow;
`ifdef OVERFLOW_STICKY_EN
  logic              ovf_clr;

  modport master (output pulse, output ovf_clr,
                  input led, input busy, input pend_count, input overflow);
  modport slave  (input pulse, input ovf_clr,
                  output led, output busy, output pend_count, output overflow);
`else
  modport master (output pulse,
                  input led, input busy, input pend_count, input overflow);
  modport slave  (input pulse,
                  output led, output busy, output pend_count, output overflow);
`endif
endinterface

// File: rtl/event_blinker.sv
// ----------------------------------------------------------------------------
// event_blinker
// Purpose : turns 1-clk event pulses into human-visible LED blinks. Each
//           accepted event produces one ON window followed by one OFF gap.
//           Events arriving during a blink are queued in a saturating
//           counter and replayed back to back.
// Ports   : clk  - system clock, rising edge
//           rst  - asynchronous reset, active low
//           bus  - event_blinker_if.slave (pulse in; led, busy, pend_count,
//                  overflow out; ovf_clr in when sticky overflow is built)
// Macro   : OVERFLOW_STICKY_EN - overflow stays set after a drop until
//           ovf_clr; otherwise overflow is a 1-clk pulse per dropped event.
// All outputs come straight from flops.
// ----------------------------------------------------------------------------
module event_blinker #(
  parameter int TICK_DIV  = 500_000,
  parameter int ON_TICKS  = 20,
  parameter int OFF_TICKS = 20,
  parameter int PEND_MAX  = 7
) (
  input logic             clk,
  input logic             rst,
  event_blinker_if.slave  bus
);

  localparam int PEND_W = $clog2(PEND_MAX + 1);
  localparam int PRE_W  = $clog2(TICK_DIV);
  localparam int PH_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  state_t            r_state;
  logic [PRE_W-1:0]  r_pre;
  logic [PH_W-1:0]   r_phase;
  logic              r_led;
  logic              r_busy;
  logic [PEND_W-1:0] r_pend;
  logic              r_ovf;

  logic w_tick;
  logic w_on_end;
  logic w_off_end;
  logic w_restart;
  logic w_queue_pulse;
  logic w_drop;
  logic w_inc;

  // Tick, window-end and queue decisions for the current clock.
  always_comb begin
    w_tick        = 1'b0;
    w_on_end      = 1'b0;
    w_off_end     = 1'b0;
    w_restart     = 1'b0;
    w_queue_pulse = 1'b0;
    w_drop        = 1'b0;
    w_inc         = 1'b0;

    w_tick    = (r_pre == PRE_W'(TICK_DIV - 1));
    w_on_end  = (r_state == ST_ON)  && w_tick && (r_phase == PH_W'(ON_TICKS - 1));
    w_off_end = (r_state == ST_OFF) && w_tick && (r_phase == PH_W'(OFF_TICKS - 1));

    // End of the gap restarts ON if anything is waiting, including a pulse
    // arriving in this very clock (that pulse is consumed, never queued).
    if (w_off_end) begin
      w_restart = (r_pend != {PEND_W{1'b0}}) || bus.pulse;
    end else begin
      w_restart = 1'b0;
    end

    // Pulses during a blink are queued, except on the restarting OFF clock.
    if (bus.pulse && ((r_state == ST_ON) || ((r_state == ST_OFF) && !w_off_end))) begin
      w_queue_pulse = 1'b1;
    end else begin
      w_queue_pulse = 1'b0;
    end

    w_drop = w_queue_pulse && (r_pend == PEND_W'(PEND_MAX));
    w_inc  = w_queue_pulse && !w_drop;
  end

  // Blink FSM with prescaler, phase counter, event queue and overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_pre   <= {PRE_W{1'b0}};
      r_phase <= {PH_W{1'b0}};
      r_led   <= 1'b0;
      r_busy  <= 1'b0;
      r_pend  <= {PEND_W{1'b0}};
      r_ovf   <= 1'b0;
    end else begin
`ifdef OVERFLOW_STICKY_EN
      // A drop in the same clock as a clear keeps the flag set.
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (bus.ovf_clr) begin
        r_ovf <= 1'b0;
      end
`else
      r_ovf <= w_drop;
`endif

      // Restart consumes one queued event; a same-clock pulse replaces it.
      if (w_restart) begin
        if (!bus.pulse) begin
          r_pend <= r_pend - PEND_W'(1);
        end
      end else if (w_inc) begin
        r_pend <= r_pend + PEND_W'(1);
      end

      case (r_state)
        ST_IDLE: begin
          r_pre   <= {PRE_W{1'b0}};
          r_phase <= {PH_W{1'b0}};
          if (bus.pulse) begin
            r_state <= ST_ON;
            r_led   <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ST_ON: begin
          if (w_on_end) begin
            r_state <= ST_OFF;
            r_led   <= 1'b0;
            r_pre   <= {PRE_W{1'b0}};
            r_phase <= {PH_W{1'b0}};
          end else if (w_tick) begin
            r_pre   <= {PRE_W{1'b0}};
            r_phase <= r_phase + PH_W'(1);
          end else begin
            r_pre   <= r_pre + PRE_W'(1);
          end
        end
        ST_OFF: begin
          if (w_off_end) begin
            r_pre   <= {PRE_W{1'b0}};
            r_phase <= {PH_W{1'b0}};
            if (w_restart) begin
              r_state <= ST_ON;
              r_led   <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else if (w_tick) begin
            r_pre   <= {PRE_W{1'b0}};
            r_phase <= r_phase + PH_W'(1);
          end else begin
            r_pre   <= r_pre + PRE_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_led   <= 1'b0;
          r_busy  <= 1'b0;
          r_pre   <= {PRE_W{1'b0}};
          r_phase <= {PH_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.led        = r_led;
  assign bus.busy       = r_busy;
  assign bus.pend_count = r_pend;
  assign bus.overflow   = r_ovf;

endmodule
